ddr_axi_selftest: RTL and testbench



---
 rtl/ddr_axi_selftest_if.sv | 36 +++
 rtl/ddr_axi_selftest.sv | 182 ++++++++++++++++++
 tb/tb_ddr_axi_selftest.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_axi_selftest_if.sv
// AXI-style write/read channels between the memory self-test master and the DDR controller.
interface ddr_axi_selftest_if #(
   parameter int AW = 26,
   parameter int DW = 16
);
   logic          awvalid;
   logic          awready;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic          wvalid;
   logic          wready;
   logic          wlast;
   logic [DW-1:0] wdata;
   logic          bvalid;
   logic          bready;
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic          rvalid;
   logic          rready;
   logic          rlast;
   logic [DW-1:0] rdata;

   modport master (
      output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
             arvalid, araddr, arlen, rready,
      input  awready, wready, bvalid, arready, rvalid, rlast, rdata
   );

   modport slave (
      input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
             arvalid, araddr, arlen, rready,
      output awready, wready, bvalid, arready, rvalid, rlast, rdata
   );
endinterface

// File: rtl/ddr_axi_selftest.sv
// Memory self-test master: writes a counting pattern over a region in fixed-length bursts,
// reads it back, and reports the mismatch count and the first failing byte address.
module ddr_axi_selftest #(
   parameter int              BA_BITS   = 2,
   parameter int              ROW_BITS  = 13,
   parameter int              COL_BITS  = 11,
   parameter int              DQ_LEVEL  = 1,
   parameter int              BURST_LEN = 8,
   parameter longint unsigned BASE_ADDR = 0
) (
   input  logic                                         core_clk,
   input  logic                                         core_rst,
   input  logic                                         start_i,
   input  logic [15:0]                                  test_bursts_i,
   output logic                                         busy_o,
   output logic                                         done_o,
   output logic                                         pass_o,
   output logic [15:0]                                  err_count_o,
   output logic [BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-2:0] first_err_addr_o,
   ddr_axi_selftest_if.master                           axi
);

   localparam int            AW        = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
   localparam int            DW        = 8 << DQ_LEVEL;
   localparam int            HW        = DW / 2;
   localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
   localparam logic [AW-1:0] STEP      = AW'(BURST_LEN << DQ_LEVEL);
   localparam logic [7:0]    LAST_BEAT = 8'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   bursts_q, bursts_d;
   logic [15:0]   k_q, k_d;
   logic [7:0]    beat_q, beat_d;
   logic [HW-1:0] n_q, n_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   err_q, err_d;
   logic [AW-1:0] firstErr_q, firstErr_d;

   logic [DW-1:0] pattern;
   logic          lastBeat;
   logic [15:0]   kNext;
   logic          lastBurst;
   logic [AW-1:0] beatAddr;
   logic          rdErr;

   assign pattern   = {~n_q, n_q};
   assign lastBeat  = (beat_q == LAST_BEAT);
   assign kNext     = k_q + 16'd1;
   assign lastBurst = (kNext == bursts_q);
   assign beatAddr  = addr_q + (AW'(beat_q) << DQ_LEVEL);
   // rlast is only checked, never trusted: the beat counter alone closes a burst.
   assign rdErr     = (axi.rdata != pattern) || (axi.rlast != lastBeat);

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state_q    <= S_IDLE;
         bursts_q   <= '0;
         k_q        <= '0;
         beat_q     <= '0;
         n_q        <= '0;
         addr_q     <= '0;
         err_q      <= '0;
         firstErr_q <= '0;
      end else begin
         state_q    <= state_d;
         bursts_q   <= bursts_d;
         k_q        <= k_d;
         beat_q     <= beat_d;
         n_q        <= n_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         firstErr_q <= firstErr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bursts_d   = bursts_q;
      k_d        = k_q;
      beat_d     = beat_q;
      n_d        = n_q;
      addr_d     = addr_q;
      err_d      = err_q;
      firstErr_d = firstErr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               bursts_d   = test_bursts_i;
               k_d        = '0;
               beat_d     = '0;
               n_d        = '0;
               addr_d     = BASE;
               err_d      = '0;
               firstErr_d = '0;
               state_d    = (test_bursts_i == 16'd0) ? S_DONE : S_AW;
            end
         end
         S_AW: begin
            if (axi.awready) state_d = S_W;
         end
         S_W: begin
            if (axi.wready) begin
               n_d = n_q + HW'(1);
               if (lastBeat) begin
                  beat_d  = '0;
                  state_d = S_B;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         S_B: begin
            if (axi.bvalid) begin
               if (lastBurst) begin
                  k_d     = '0;
                  n_d     = '0;
                  addr_d  = BASE;
                  state_d = S_AR;
               end else begin
                  k_d     = kNext;
                  addr_d  = addr_q + STEP;
                  state_d = S_AW;
               end
            end
         end
         S_AR: begin
            if (axi.arready) state_d = S_R;
         end
         S_R: begin
            if (axi.rvalid) begin
               if (rdErr) begin
                  if (err_q == 16'd0) firstErr_d = beatAddr;
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               end
               n_d = n_q + HW'(1);
               if (lastBeat) begin
                  beat_d = '0;
                  if (lastBurst) begin
                     state_d = S_DONE;
                  end else begin
                     k_d     = kNext;
                     addr_d  = addr_q + STEP;
                     state_d = S_AR;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign axi.awvalid = (state_q == S_AW);
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = LAST_BEAT;
   assign axi.wvalid  = (state_q == S_W);
   assign axi.wlast   = (state_q == S_W) && lastBeat;
   assign axi.wdata   = pattern;
   assign axi.bready  = (state_q == S_B);
   assign axi.arvalid = (state_q == S_AR);
   assign axi.araddr  = addr_q;
   assign axi.arlen   = LAST_BEAT;
   assign axi.rready  = (state_q == S_R);

   assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o           = (state_q == S_DONE);
   assign pass_o           = (state_q == S_DONE) && (err_q == 16'd0);
   assign err_count_o      = err_q;
   assign first_err_addr_o = firstErr_q;

endmodule

// File: tb/tb_ddr_axi_selftest.sv
// Directed bench for ddr_axi_selftest: behavioural memory slave with optional stalls,
// read corruption and rlast faults, plus a second instance parked at the top of the address space.
module tb_ddr_axi_selftest;

   localparam int AW = 26;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          start, start2;
   logic [15:0]   bursts;
   logic          busy, done, pass;
   logic [15:0]   errCount;
   logic [AW-1:0] firstErr;
   logic          busy2, done2, pass2;
   logic [15:0]   errCount2;
   logic [AW-1:0] firstErr2;

   ddr_axi_selftest_if #(.AW(AW), .DW(DW)) axi ();
   ddr_axi_selftest_if #(.AW(AW), .DW(DW)) axi2 ();

   ddr_axi_selftest #(.BURST_LEN(8)) dut (
      .core_clk(clk), .core_rst(rst), .start_i(start), .test_bursts_i(bursts),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(errCount),
      .first_err_addr_o(firstErr), .axi(axi)
   );

   ddr_axi_selftest #(.BURST_LEN(8), .BASE_ADDR(64'h3FF_FFF0)) dutWrap (
      .core_clk(clk), .core_rst(rst), .start_i(start2), .test_bursts_i(16'd2),
      .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(errCount2),
      .first_err_addr_o(firstErr2), .axi(axi2)
   );

   assign axi2.awready = 1'b1;
   assign axi2.wready  = 1'b1;
   assign axi2.bvalid  = 1'b1;
   assign axi2.arready = 1'b1;
   assign axi2.rvalid  = 1'b0;
   assign axi2.rlast   = 1'b0;
   assign axi2.rdata   = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit            stall;
   int            flipBeat;
   bit            protoErr;
   logic [15:0]   mem [0:255];
   logic [AW-1:0] awLog [0:15];
   logic [7:0]    awlenLog [0:15];
   logic [15:0]   wLog [0:63];
   logic          wlastLog [0:63];
   int            awCount, wCount, bCount, arCount, rCount, rGlobal, stableErr;
   logic [AW-1:0] curAw, curAr, wa, ra;
   int            wBeat, rBeat, rBeatsLeft;
   bit            pendingB;
   bit            awPend, wPend, arPend;
   logic [AW-1:0] awPrev, arPrev;
   logic [15:0]   wPrev;
   logic          wlPrev;
   logic [15:0]   rd;
   logic          rl;
   logic [AW-1:0] aw2Log [0:3];
   logic [AW-1:0] ar2Addr;
   int            aw2Count, ar2Count;

   // Handshakes are seen at the negedge before the edge that completes them.
   always @(negedge clk) begin
      if (rst) begin
         pendingB = 0; rBeatsLeft = 0; wBeat = 0; rBeat = 0;
         awPend = 0; wPend = 0; arPend = 0;
      end else begin
         if (awPend && (axi.awvalid !== 1'b1 || axi.awaddr !== awPrev)) stableErr++;
         if (wPend && (axi.wvalid !== 1'b1 || axi.wdata !== wPrev || axi.wlast !== wlPrev)) stableErr++;
         if (arPend && (axi.arvalid !== 1'b1 || axi.araddr !== arPrev)) stableErr++;
         awPend = axi.awvalid && !axi.awready; awPrev = axi.awaddr;
         wPend  = axi.wvalid && !axi.wready;   wPrev = axi.wdata; wlPrev = axi.wlast;
         arPend = axi.arvalid && !axi.arready; arPrev = axi.araddr;
         if (axi.awvalid && axi.awready) begin
            awLog[awCount % 16] = axi.awaddr;
            awlenLog[awCount % 16] = axi.awlen;
            curAw = axi.awaddr;
            wBeat = 0;
            awCount++;
         end
         if (axi.wvalid && axi.wready) begin
            wa = curAw + AW'(2 * wBeat);
            mem[wa[8:1]] = axi.wdata;
            wLog[wCount % 64] = axi.wdata;
            wlastLog[wCount % 64] = axi.wlast;
            wCount++;
            wBeat++;
            if (axi.wlast) pendingB = 1;
         end
         if (axi.bvalid && axi.bready) begin
            pendingB = 0;
            bCount++;
         end
         if (axi.arvalid && axi.arready) begin
            curAr = axi.araddr;
            rBeat = 0;
            rBeatsLeft = 8;
            arCount++;
         end
         if (axi.rvalid && axi.rready) begin
            rBeat++;
            rBeatsLeft--;
            rGlobal++;
            rCount++;
         end
         if (axi2.awvalid && axi2.awready) begin
            if (aw2Count < 4) aw2Log[aw2Count] = axi2.awaddr;
            aw2Count++;
         end
         if (axi2.arvalid && axi2.arready) begin
            if (ar2Count == 0) ar2Addr = axi2.araddr;
            ar2Count++;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0;
         axi.rvalid = 0; axi.rlast = 0; axi.rdata = '0;
      end else begin
         #1;
         axi.awready = !stall || ($urandom_range(0, 1) == 1);
         axi.wready  = !stall || ($urandom_range(0, 1) == 1);
         axi.arready = !stall || ($urandom_range(0, 1) == 1);
         axi.bvalid  = pendingB && (!stall || ($urandom_range(0, 1) == 1));
         if (rBeatsLeft > 0 && (!stall || ($urandom_range(0, 1) == 1))) begin
            ra = curAr + AW'(2 * rBeat);
            rd = mem[ra[8:1]];
            if (rGlobal == flipBeat) rd = rd ^ 16'h0008;
            rl = (rBeat == 7);
            if (protoErr && (rGlobal == 3 || rGlobal == 7)) rl = !rl;
            axi.rvalid = 1; axi.rdata = rd; axi.rlast = rl;
         end else begin
            axi.rvalid = 0; axi.rdata = '0; axi.rlast = 0;
         end
      end
   end

   task automatic applyStart(input logic [15:0] nb);
      @(negedge clk);
      awCount = 0; wCount = 0; bCount = 0; arCount = 0; rCount = 0; rGlobal = 0; stableErr = 0;
      bursts = nb;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic waitDone(input int limit, input string name);
      int i;
      for (i = 0; i < limit && done !== 1'b1; i++) @(negedge clk);
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_timeout done=%b want=1 after %0d cycles", name, done, limit);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, pass, errCount, firstErr, axi.awvalid, axi.wvalid, axi.wlast,
           axi.bready, axi.arvalid, axi.rready, axi.awaddr, axi.araddr} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_zero got=%0h want=0", {busy, done, pass, errCount, firstErr,
                  axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready,
                  axi.awaddr, axi.araddr});
      end
      total++;
      if ({axi.awlen, axi.arlen, axi.wdata} !== {8'd7, 8'd7, 16'hFF00}) begin
         bad++;
         $display("[TB] FAIL reset_const got=%0h want=0707ff00", {axi.awlen, axi.arlen, axi.wdata});
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0]  nn;
      logic [15:0] exp;
      applyStart(16'd2);
      total++;
      if ({busy, axi.awvalid, done} !== 3'b110) begin
         bad++;
         $display("[TB] FAIL basic_start got=%b want=110", {busy, axi.awvalid, done});
      end
      waitDone(300, "basic");
      total++;
      if ({pass, busy, errCount} !== {1'b1, 1'b0, 16'd0}) begin
         bad++;
         $display("[TB] FAIL basic_result pass/busy/err got=%0h want=20000", {pass, busy, errCount});
      end
      total++;
      if ({awCount, awLog[0], awLog[1], awlenLog[0], awlenLog[1]} !==
          {32'd2, 26'h0, 26'h10, 8'd7, 8'd7}) begin
         bad++;
         $display("[TB] FAIL basic_aw got cnt=%0d a0=%0h a1=%0h len=%0d/%0d want 2 0 10 7/7",
                  awCount, awLog[0], awLog[1], awlenLog[0], awlenLog[1]);
      end
      total++;
      if ({wCount, arCount, rCount} !== {32'd16, 32'd2, 32'd16}) begin
         bad++;
         $display("[TB] FAIL basic_counts got w=%0d ar=%0d r=%0d want 16 2 16", wCount, arCount, rCount);
      end
      for (int i = 0; i < 16; i++) begin
         nn  = 8'(i);
         exp = {~nn, nn};
         total++;
         if (wLog[i] !== exp || wlastLog[i] !== (i == 7 || i == 15)) begin
            bad++;
            $display("[TB] FAIL basic_wbeat%0d got=%h/%b want=%h/%b", i, wLog[i], wlastLog[i],
                     exp, (i == 7 || i == 15));
         end
      end
   endtask

   task automatic test_zero_bursts();
      applyStart(16'd0);
      total++;
      if ({done, busy, pass, axi.awvalid} !== 4'b1010) begin
         bad++;
         $display("[TB] FAIL zero_start done/busy/pass/awvalid got=%b want=1010",
                  {done, busy, pass, axi.awvalid});
      end
      repeat (5) @(negedge clk);
      total++;
      if ({awCount, arCount, 31'd0, done} !== {32'd0, 32'd0, 32'd1}) begin
         bad++;
         $display("[TB] FAIL zero_idle got aw=%0d ar=%0d done=%b want 0 0 1", awCount, arCount, done);
      end
   endtask

   task automatic test_backpressure();
      stall = 1;
      applyStart(16'd2);
      waitDone(3000, "bp");
      total++;
      if ({wCount, rCount, bCount} !== {32'd16, 32'd16, 32'd2}) begin
         bad++;
         $display("[TB] FAIL bp_counts got w=%0d r=%0d b=%0d want 16 16 2", wCount, rCount, bCount);
      end
      total++;
      if ({pass, errCount} !== {1'b1, 16'd0}) begin
         bad++;
         $display("[TB] FAIL bp_result got pass=%b err=%0d want 1 0", pass, errCount);
      end
      total++;
      if (stableErr !== 0) begin
         bad++;
         $display("[TB] FAIL bp_stable got=%0d unstable cycles want=0", stableErr);
      end
      stall = 0;
   endtask

   task automatic test_bit_flip();
      flipBeat = 11;
      applyStart(16'd2);
      waitDone(300, "flip");
      total++;
      if ({pass, errCount, firstErr} !== {1'b0, 16'd1, 26'h16}) begin
         bad++;
         $display("[TB] FAIL flip_result got pass=%b err=%0d addr=%0h want 0 1 16", pass, errCount, firstErr);
      end
      flipBeat = -1;
   endtask

   task automatic test_protocol();
      protoErr = 1;
      applyStart(16'd2);
      waitDone(300, "proto");
      total++;
      if ({pass, errCount, firstErr} !== {1'b0, 16'd2, 26'h6}) begin
         bad++;
         $display("[TB] FAIL proto_result got pass=%b err=%0d addr=%0h want 0 2 6", pass, errCount, firstErr);
      end
      total++;
      if ({rCount, arCount} !== {32'd16, 32'd2}) begin
         bad++;
         $display("[TB] FAIL proto_beats got r=%0d ar=%0d want 16 2", rCount, arCount);
      end
      protoErr = 0;
   endtask

   task automatic test_restart();
      applyStart(16'd2);
      total++;
      if ({done, busy, errCount, firstErr} !== {1'b0, 1'b1, 16'd0, 26'h0}) begin
         bad++;
         $display("[TB] FAIL restart_clear got done=%b busy=%b err=%0d addr=%0h want 0 1 0 0",
                  done, busy, errCount, firstErr);
      end
      waitDone(300, "restart");
      total++;
      if (pass !== 1'b1) begin
         bad++;
         $display("[TB] FAIL restart_pass got=%b want=1", pass);
      end
   endtask

   task automatic test_wrap();
      int i;
      @(negedge clk);
      start2 = 1;
      @(negedge clk);
      start2 = 0;
      for (i = 0; i < 100 && ar2Count == 0; i++) @(negedge clk);
      total++;
      if ({aw2Count, aw2Log[0], aw2Log[1], ar2Addr} !== {32'd2, 26'h3FF_FFF0, 26'h0, 26'h3FF_FFF0}) begin
         bad++;
         $display("[TB] FAIL wrap_addr got n=%0d a0=%0h a1=%0h ar=%0h want 2 3fffff0 0 3fffff0",
                  aw2Count, aw2Log[0], aw2Log[1], ar2Addr);
      end
   endtask

   task automatic test_reset_mid_w();
      int i;
      applyStart(16'd3);
      for (i = 0; i < 50 && axi.wvalid !== 1'b1; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      total++;
      if (axi.wvalid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midw_inW got wvalid=%b want=1", axi.wvalid);
      end
      rst = 1;
      #1;
      total++;
      if ({busy, done, axi.wvalid, axi.wlast, axi.awvalid, axi.bready, axi.awaddr, axi.wdata} !==
          {6'b0, 26'h0, 16'hFF00}) begin
         bad++;
         $display("[TB] FAIL midw_reset got=%0h want=ff00", {busy, done, axi.wvalid, axi.wlast,
                  axi.awvalid, axi.bready, axi.awaddr, axi.wdata});
      end
      repeat (2) @(negedge clk);
      rst = 0;
      applyStart(16'd2);
      waitDone(300, "midw");
      total++;
      if ({pass, errCount, wCount, rCount} !== {1'b1, 16'd0, 32'd16, 32'd16}) begin
         bad++;
         $display("[TB] FAIL midw_rerun got pass=%b err=%0d w=%0d r=%0d want 1 0 16 16",
                  pass, errCount, wCount, rCount);
      end
   endtask

   initial begin
      start = 0; start2 = 0; bursts = '0; stall = 0; flipBeat = -1; protoErr = 0;
      awCount = 0; wCount = 0; bCount = 0; arCount = 0; rCount = 0; rGlobal = 0; stableErr = 0;
      aw2Count = 0; ar2Count = 0; ar2Addr = '0; pendingB = 0; rBeatsLeft = 0;
      for (int i = 0; i < 4; i++) aw2Log[i] = '0;
      test_reset();
      test_basic();
      test_zero_bursts();
      test_backpressure();
      test_bit_flip();
      test_protocol();
      test_restart();
      test_wrap();
      test_reset_mid_w();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
